instr_cache: RTL

//  Direct-mapped, read-only instruction cache feeding the fetch stage.

---
 rtl/instr_cache.sv | 124 ++++++++++++
 1 files changed

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache with single-line refill.
// Zero-latency hit path; misses stall fetch and refill over a req/ready port.
module instr_cache #(
    parameter int          NUM_LINES      = 4,
    parameter int          WORDS_PER_LINE = 4,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [31:0]                  pc,
    input  logic                         fetch_en,
    input  logic                         invalidate,
    output logic [31:0]                  instr,
    output logic                         icache_stall,
    output logic                         mem_req,
    output logic [31:0]                  mem_addr,
    input  logic                         mem_ready,
    input  logic [32*WORDS_PER_LINE-1:0] mem_rdata,
    output logic [31:0]                  miss_count
);

    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int WOFF_W = $clog2(WORDS_PER_LINE);
    localparam int OFF    = 2 + WOFF_W;
    localparam int TAG_W  = 32 - OFF - IDX_W;

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t state;

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tag_arr  [NUM_LINES];
    logic [31:0]          data_arr [NUM_LINES][WORDS_PER_LINE];
    logic                 inv_pending;

    logic [WOFF_W-1:0] pc_word;
    logic [IDX_W-1:0]  pc_idx;
    logic [TAG_W-1:0]  pc_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              hit;
    logic              miss;
    logic              unused_pc_bits;

    assign pc_word  = pc[2 +: WOFF_W];
    assign pc_idx   = pc[OFF +: IDX_W];
    assign pc_tag   = pc[31 : OFF+IDX_W];
    assign fill_idx = mem_addr[OFF +: IDX_W];
    assign fill_tag = mem_addr[31 : OFF+IDX_W];

    assign unused_pc_bits = ^pc[1:0];

    assign hit  = fetch_en && valid[pc_idx] && (tag_arr[pc_idx] == pc_tag) && (state == IDLE);
    assign miss = fetch_en && !hit && (state == IDLE);

    assign mem_req = (state == REQ);

    // Hit data is returned in the same cycle; everything else sees a NOP.
    always_comb begin
        instr        = NOP_INSTR;
        icache_stall = 1'b0;
        if (!reset) begin
            if (hit) begin
                instr = data_arr[pc_idx][pc_word];
            end
            icache_stall = (state == REQ) || miss;
        end
    end

    // Refill controller: capture miss line, wait for memory, install line.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            valid       <= '0;
            mem_addr    <= '0;
            miss_count  <= '0;
            inv_pending <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (invalidate) begin
                        valid <= '0;
                    end
                    if (miss) begin
                        mem_addr    <= {pc[31:OFF], {OFF{1'b0}}};
                        inv_pending <= 1'b0;
                        state       <= REQ;
                        if (miss_count != 32'hFFFF_FFFF) begin
                            miss_count <= miss_count + 32'd1;
                        end
                    end
                end
                REQ: begin
                    if (invalidate) begin
                        valid <= '0;
                    end
                    if (mem_ready) begin
                        // A line fetched across an invalidate must stay invalid.
                        valid[fill_idx] <= !(inv_pending || invalidate);
                        inv_pending     <= 1'b0;
                        state           <= IDLE;
                    end else if (invalidate) begin
                        inv_pending <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and data storage written on the refill handshake.
    always_ff @(posedge clock) begin
        if (state == REQ && mem_ready && !reset) begin
            tag_arr[fill_idx] <= fill_tag;
            for (int i = 0; i < WORDS_PER_LINE; i++) begin
                data_arr[fill_idx][i] <= mem_rdata[32*i +: 32];
            end
        end
    end

endmodule
